// File: rtl/dot_product_pkg.sv
// Shared constants and FSM encoding for the dot-product accumulator.
package dot_product_pkg;

  localparam int LEN_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/array_mul.sv
// Unsigned shift-and-add array multiplier.
module array_mul #(
  parameter int W = 8
) (
  input  logic [W-1:0]   mul_cand,
  input  logic [W-1:0]   mul_ier,
  output logic [2*W-1:0] result
);

  always_comb begin
    result = '0;
    for (int i = 0; i < W; i++) begin
      if (mul_ier[i]) begin
        result = result + ((2*W)'(mul_cand) << i);
      end
    end
  end

endmodule

// File: rtl/dot_product_acc.sv
// Streaming dot-product accumulator: operand regs feed the
// multiplier, the product is added to acc one cycle later.
module dot_product_acc
  import dot_product_pkg::*;
#(
  parameter int K     = 8,
  parameter int ACC_W = 2*K+8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [K-1:0]     a,
  input  logic [K-1:0]     x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc,
  output logic             ovf,
  output logic             busy
);

  state_e state_q, state_d;

  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [K-1:0]     a_q, a_d;
  logic [K-1:0]     x_q, x_d;
  logic             s1_vld_q, s1_vld_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  logic [2*K-1:0]   prod;
  logic [ACC_W:0]   sum;
  logic [LEN_W-1:0] cnt_inc;
  logic             accept;
  logic             last;
  logic             go;

  array_mul #(.W(K)) u_mul (
    .mul_cand (a_q),
    .mul_ier  (x_q),
    .result   (prod)
  );

  assign sum     = {1'b0, acc_q} + (ACC_W+1)'(prod);
  assign cnt_inc = cnt_q + LEN_W'(1);
  assign accept  = in_valid && (state_q == S_ACCUM);
  assign last    = accept && (cnt_inc == len_q);
  assign go      = start && (state_q == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      a_q      <= '0;
      x_q      <= '0;
      s1_vld_q <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      x_q      <= x_d;
      s1_vld_q <= s1_vld_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (len != '0) ? S_ACCUM : S_DONE;
        end
      end
      S_ACCUM: if (last)       state_d = S_DRAIN;
      // The add of the last product lands on the edge s1 clears.
      S_DRAIN: if (!s1_vld_q)  state_d = S_DONE;
      S_DONE:  if (out_ready)  state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  always_comb begin
    len_d    = len_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    x_d      = x_q;
    s1_vld_d = accept;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    if (accept) begin
      a_d   = a;
      x_d   = x;
      cnt_d = cnt_inc;
    end
    if (s1_vld_q) begin
      acc_d = sum[ACC_W-1:0];
      ovf_d = ovf_q | sum[ACC_W];
    end
    if (go) begin
      len_d = len;
      cnt_d = '0;
      acc_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    in_ready  = (state_q == S_ACCUM);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    acc       = acc_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_dot_product_acc.sv
// Directed bench with a result scoreboard for dot_product_acc.
module tb_dot_product_acc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  x = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, ovf, busy;
  logic [23:0] acc;
  logic        in_ready16, out_valid16, ovf16, busy16;
  logic [15:0] acc16;

  dot_product_acc #(.K(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .x(x),
    .out_valid(out_valid), .out_ready(out_ready),
    .acc(acc), .ovf(ovf), .busy(busy)
  );

  dot_product_acc #(.K(8), .ACC_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready16), .a(a), .x(x),
    .out_valid(out_valid16), .out_ready(out_ready),
    .acc(acc16), .ovf(ovf16), .busy(busy16)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [23:0] a24;
    logic        o24;
    logic [15:0] a16;
    logic        o16;
  } exp_t;

  exp_t sb[$];
  int   pa[$];
  int   px[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_acc"}, acc, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic run(input int gap, input int hold,
                     input bit lat, input bit poke);
    exp_t   e;
    longint s;
    int     n;
    int     w;
    int     t;
    s = 0;
    t = 0;
    n = pa.size();
    for (int i = 0; i < n; i++) s += longint'(pa[i] * px[i]);
    e.a24 = s[23:0];
    e.o24 = (s >= (longint'(1) << 24));
    e.a16 = s[15:0];
    e.o16 = (s >= (longint'(1) << 16));
    sb.push_back(e);
    start = 1'b1;
    len = 8'(n);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      a = 8'(pa[i]);
      x = 8'(px[i]);
      w = 0;
      while (!in_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk("in_ready", in_ready, 1);
      t = cyc;
      @(negedge clk);
      in_valid = 1'b0;
      a = 8'hA5;
      x = 8'h5A;
      if (i < n-1) begin
        for (int g = 0; g < gap; g++) begin
          if (poke && g == 0) begin
            start = 1'b1;
            len = 8'd9;
          end
          @(negedge clk);
          start = 1'b0;
        end
      end
    end
    if (n > 0) chk("in_ready_drop", in_ready, 0);
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("out_valid", out_valid, 1);
    if (lat) chk("latency", cyc - t, 3);
    if (n == 0) chk("len0_wait", w, 0);
    e = sb.pop_front();
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_acc", acc, e.a24);
      @(negedge clk);
    end
    chk("acc", acc, e.a24);
    chk("ovf", ovf, e.o24);
    chk("acc16", acc16, e.a16);
    chk("ovf16", ovf16, e.o16);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);
    chk("idle_acc", acc, e.a24);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 chk_idle("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    pa = '{1};
    px = '{1};
    run(0, 0, 1, 0);

    pa = '{170, 240, 255, 15};
    px = '{85, 15, 1, 1};
    run(0, 0, 1, 0);

    pa = '{255, 255};
    px = '{255, 255};
    run(0, 0, 1, 0);

    pa = '{200, 3, 255};
    px = '{100, 7, 255};
    run(2, 5, 1, 1);

    pa = '{};
    px = '{};
    run(0, 0, 0, 0);

    start = 1'b1;
    len = 8'd4;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      a = 8'd200;
      x = 8'd200;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_idle("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;

    pa = '{170, 240, 255, 15};
    px = '{85, 15, 1, 1};
    run(0, 0, 1, 0);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("quiet_valid", out_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
